global_control: RTL

- Single shared sequencer for the SIMD core array; sits directly upstream of every core's local control.
- Owns the global program counter and the call/return stack.
- Drives the instruction-memory address, next_program_counter, next_stack_pointer and global_enable to all cores, and consumes their per-core diverge flags to decide conditional branches.

---
 rtl/global_control_pkg.sv | 61 ++++++
 rtl/global_control_return_stack.sv | 53 +++++
 rtl/global_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/global_control_pkg.sv
// Instruction-set types, predicates and FSM state encoding shared by global_control
// and its return stack.
package global_control_pkg;

  localparam int PC_W            = 8;
  localparam int SP_W            = 3;
  localparam int REL_W           = 6;
  localparam int STACK_DEPTH_DEF = 2 ** SP_W;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [SP_W-1:0]  sp_t;
  typedef logic [REL_W-1:0] relative_branch_address_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_BRA  = 4'h2,
    OP_BRC  = 4'h3,
    OP_CALL = 4'h4,
    OP_RET  = 4'h5,
    OP_HALT = 4'h6
  } opcode_t;

  typedef struct packed {
    opcode_t                  opcode;
    logic [5:0]               reserved;
    relative_branch_address_t rel;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } global_state_t;

  function automatic logic is_unconditional_branch(input opcode_t op);
    return op == OP_BRA;
  endfunction

  function automatic logic is_conditional_branch(input opcode_t op);
    return op == OP_BRC;
  endfunction

  function automatic logic is_call(input opcode_t op);
    return op == OP_CALL;
  endfunction

  function automatic logic is_return(input opcode_t op);
    return op == OP_RET;
  endfunction

  function automatic logic is_halt(input opcode_t op);
    return op == OP_HALT;
  endfunction

  // Sign-extended to PC width so a plain add wraps modulo 2**PC_W.
  function automatic pc_t get_relative_branch_addr(input instruction_t ins);
    return pc_t'({{(PC_W-REL_W){ins.rel[REL_W-1]}}, ins.rel});
  endfunction

endpackage

// File: rtl/global_control_return_stack.sv
// Return-address stack: synchronous push/pop, async read of the top entry.
// sp stays at DEPTH-1 on the last push; full_q marks that the final slot is occupied.
module return_stack
  import global_control_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic clear_i,
  input  pc_t  push_data_i,
  output sp_t  sp_o,
  output sp_t  sp_push_o,
  output sp_t  sp_pop_o,
  output logic full_o,
  output logic empty_o,
  output pc_t  top_o
);

  localparam sp_t SP_MAX = sp_t'(DEPTH - 1);

  pc_t  mem_q [DEPTH];
  sp_t  sp_q;
  logic full_q;

  assign sp_o      = sp_q;
  assign full_o    = full_q;
  assign empty_o   = (sp_q == '0) && !full_q;
  assign sp_push_o = (sp_q == SP_MAX) ? sp_q : sp_q + sp_t'(1);
  assign sp_pop_o  = full_q ? sp_q : sp_q - sp_t'(1);
  assign top_o     = full_q ? mem_q[sp_q] : mem_q[sp_q - sp_t'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q   <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      sp_q   <= '0;
      full_q <= 1'b0;
    end else if (push_i && !full_q) begin
      mem_q[sp_q] <= push_data_i;
      if (sp_q == SP_MAX) full_q <= 1'b1;
      else                sp_q   <= sp_q + sp_t'(1);
    end else if (pop_i && !empty_o) begin
      if (full_q) full_q <= 1'b0;
      else        sp_q   <= sp_q - sp_t'(1);
    end
  end

endmodule

// File: rtl/global_control.sv
// Global sequencer for the SIMD core array: owns the PC and the call/return stack.
// Define GLOBAL_CONTROL_PERF_EN to add the cycle_count / divergence_count outputs.
module global_control
  import global_control_pkg::*;
#(
  parameter int NUM_CORES   = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  instruction_t         instruction,
  input  logic [NUM_CORES-1:0] diverge,
  output pc_t                  program_counter,
  output pc_t                  next_program_counter,
  output sp_t                  next_stack_pointer,
  output logic                 global_enable,
  output logic                 halted,
  output logic                 error
`ifdef GLOBAL_CONTROL_PERF_EN
  ,
  output logic [31:0]          cycle_count,
  output logic [31:0]          divergence_count
`endif
);

  global_state_t state_q;
  pc_t           pc_q, pc_d, target;
  sp_t           sp_d, sp, sp_push, sp_pop;
  pc_t           stack_top;
  logic          error_q, global_enable_q, halted_q;
  logic          push, pop, err_evt, halt_evt, full, empty, clear;
  opcode_t       op;
  logic          unused_reserved;

  assign op              = instruction.opcode;
  assign target          = pc_q + get_relative_branch_addr(instruction);
  assign unused_reserved = ^instruction.reserved;
  assign clear           = (state_q == HALT) && start;

  return_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .clear_i    (clear),
    .push_data_i(pc_q + pc_t'(1)),
    .sp_o       (sp),
    .sp_push_o  (sp_push),
    .sp_pop_o   (sp_pop),
    .full_o     (full),
    .empty_o    (empty),
    .top_o      (stack_top)
  );

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp;
    push     = 1'b0;
    pop      = 1'b0;
    err_evt  = 1'b0;
    halt_evt = 1'b0;
    if (state_q == RUN) begin
      pc_d = pc_q + pc_t'(1);
      if (is_unconditional_branch(op)) begin
        pc_d = target;
      end else if (is_conditional_branch(op)) begin
        if (&diverge) pc_d = target;
      end else if (is_call(op)) begin
        if (full) begin
          err_evt = 1'b1;
          pc_d    = pc_q;
        end else begin
          push = 1'b1;
          pc_d = target;
          sp_d = sp_push;
        end
      end else if (is_return(op)) begin
        if (empty) begin
          err_evt = 1'b1;
          pc_d    = pc_q;
        end else begin
          pop  = 1'b1;
          pc_d = stack_top;
          sp_d = sp_pop;
        end
      end else if (is_halt(op)) begin
        halt_evt = 1'b1;
        pc_d     = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pc_q            <= '0;
      error_q         <= 1'b0;
      global_enable_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q         <= RUN;
          global_enable_q <= 1'b1;
        end
        RUN: begin
          pc_q <= pc_d;
          if (halt_evt || err_evt) begin
            state_q         <= HALT;
            global_enable_q <= 1'b0;
            halted_q        <= 1'b1;
            error_q         <= error_q | err_evt;
          end
        end
        HALT: if (start) begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
          error_q  <= 1'b0;
          pc_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign program_counter      = pc_q;
  assign next_program_counter = pc_d;
  assign next_stack_pointer   = sp_d;
  assign global_enable        = global_enable_q;
  assign halted               = halted_q;
  assign error                = error_q;

`ifdef GLOBAL_CONTROL_PERF_EN
  logic [31:0] cycle_count_q, divergence_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q      <= '0;
      divergence_count_q <= '0;
    end else if (clear) begin
      cycle_count_q      <= '0;
      divergence_count_q <= '0;
    end else if (state_q == RUN) begin
      if (~&cycle_count_q) cycle_count_q <= cycle_count_q + 32'd1;
      // Partial divergence only: some but not all cores take the branch.
      if (is_conditional_branch(op) && |diverge && !(&diverge) && ~&divergence_count_q)
        divergence_count_q <= divergence_count_q + 32'd1;
    end
  end

  assign cycle_count      = cycle_count_q;
  assign divergence_count = divergence_count_q;
`endif

endmodule
